// File: rtl/inst_encoder.sv
// Packs decoded RV32IM fields into a 32-bit instruction word and streams it with a write address.
// Uses a single-entry output register with a valid/ready handshake and a saturating count of emitted words.
module inst_encoder #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_func3,
  input  logic              in_fun7,
  input  logic              in_mulbit,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_illegal,
  output logic [15:0]       inst_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [6:0]  opc;
  logic [31:0] enc_inst;
  logic        enc_illegal;
  logic        accept;
  logic        drain;

  assign opc      = {in_opcode, 2'b11};
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_comb begin
    enc_inst    = NOP;
    enc_illegal = 1'b0;
    case (in_fmt)
      3'd0: enc_inst = {1'b0, in_fun7, 4'b0000, in_mulbit, in_rs2, in_rs1, in_func3, in_rd, opc};
      3'd1: enc_inst = {in_imm[11:0], in_rs1, in_func3, in_rd, opc};
      3'd2: enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], opc};
      3'd3: begin
        if (in_imm[0]) enc_illegal = 1'b1;
        else enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                         in_imm[4:1], in_imm[11], opc};
      end
      3'd4: enc_inst = {in_imm[31:12], in_rd, opc};
      3'd5: begin
        if (in_imm[0]) enc_illegal = 1'b1;
        else enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      end
      default: enc_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_inst    <= '0;
      out_illegal <= 1'b0;
      out_addr    <= BASE_ADDR;
      inst_count  <= '0;
    end else begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_inst    <= enc_inst;
        out_illegal <= enc_illegal;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      // Address/count track drained words; clr overrides a simultaneous drain.
      if (clr) begin
        out_addr   <= BASE_ADDR;
        inst_count <= '0;
      end else if (drain) begin
        out_addr <= out_addr + ADDR_W'(4);
        if (inst_count != 16'hFFFF) inst_count <= inst_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed self-checking bench for inst_encoder against a field-arithmetic reference model.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, out_ready;
  logic [2:0]  in_fmt, in_func3;
  logic [4:0]  in_opcode, in_rd, in_rs1, in_rs2;
  logic        in_fun7, in_mulbit;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_inst, out_addr;
  logic [15:0] inst_count;
  logic        in_ready2, out_valid2, out_illegal2;
  logic [31:0] out_inst2;
  logic [3:0]  out_addr2;
  logic [15:0] inst_count2;

  int checks = 0;
  int failures = 0;

  // reference state
  logic        m_valid, m_ill;
  logic [31:0] m_inst, m_addr;
  logic [3:0]  m2_addr;
  int unsigned m_count;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_func3(in_func3), .in_fun7(in_fun7),
    .in_mulbit(in_mulbit), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .out_illegal(out_illegal), .inst_count(inst_count));

  inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_func3(in_func3), .in_fun7(in_fun7),
    .in_mulbit(in_mulbit), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2), .out_addr(out_addr2),
    .out_illegal(out_illegal2), .inst_count(inst_count2));

  // {illegal, inst} from the architectural field placement rules
  function automatic logic [32:0] ref_enc(int unsigned fmt, int unsigned op, int unsigned f3,
      int unsigned f7, int unsigned mb, int unsigned rd, int unsigned rs1, int unsigned rs2,
      int unsigned imm);
    int unsigned o, base;
    o = op * 4 + 3;
    base = (rs1 << 15) | (f3 << 12);
    case (fmt)
      0: return {1'b0, 32'((f7 << 30) | (mb << 25) | (rs2 << 20) | base | (rd << 7) | o)};
      1: return {1'b0, 32'(((imm % 4096) << 20) | base | (rd << 7) | o)};
      2: return {1'b0, 32'((((imm >> 5) % 128) << 25) | (rs2 << 20) | base | ((imm % 32) << 7) | o)};
      3: if (imm % 2 == 1) return {1'b1, 32'h13};
         else return {1'b0, 32'((((imm >> 12) % 2) << 31) | (((imm >> 5) % 64) << 25) | (rs2 << 20)
                      | base | (((imm >> 1) % 16) << 8) | (((imm >> 11) % 2) << 7) | o)};
      4: return {1'b0, 32'((imm / 4096) * 4096 + rd * 128 + o)};
      5: if (imm % 2 == 1) return {1'b1, 32'h13};
         else return {1'b0, 32'((((imm >> 20) % 2) << 31) | (((imm >> 1) % 1024) << 21)
                      | (((imm >> 11) % 2) << 20) | (((imm >> 12) % 256) << 12) | (rd << 7) | o)};
      default: return {1'b1, 32'h13};
    endcase
  endfunction

  task automatic set_fields(int unsigned fmt, int unsigned op, int unsigned f3, int unsigned f7,
      int unsigned mb, int unsigned rd, int unsigned rs1, int unsigned rs2, logic [31:0] imm);
    in_fmt = 3'(fmt); in_opcode = 5'(op); in_func3 = 3'(f3); in_fun7 = 1'(f7);
    in_mulbit = 1'(mb); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
  endtask

  // advance the model across one edge from the currently driven inputs, then clock
  task automatic tick();
    logic [32:0] e;
    logic acc, drn;
    e = ref_enc(in_fmt, in_opcode, in_func3, in_fun7, in_mulbit, in_rd, in_rs1, in_rs2, in_imm);
    if (!rst_n) begin
      m_valid = 0; m_inst = 0; m_ill = 0; m_addr = 0; m2_addr = 0; m_count = 0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      drn = m_valid && out_ready;
      if (acc) begin m_valid = 1; m_inst = e[31:0]; m_ill = e[32]; end
      else if (drn) m_valid = 0;
      if (clr) begin m_addr = 0; m2_addr = 0; m_count = 0; end
      else if (drn) begin
        m_addr = m_addr + 4; m2_addr = 4'((m2_addr + 4) % 16);
        if (m_count < 65535) m_count++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clr = 0; in_valid = 0; out_ready = 0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got %h want 0", out_inst); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got %b want 0", out_illegal); end
    checks++; if (out_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got %h want 0", out_addr); end
    checks++; if (inst_count !== 16'h0) begin failures++; $display("FAIL reset_count got %h want 0", inst_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [31:0] want [3];
    want[0] = 32'h403100B3; want[1] = 32'h027302B3; want[2] = 32'hFE208EE3;
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_fields(0, 5'h0C, 0, 1, 0, 1, 2, 3, 0);
        1: set_fields(0, 5'h0C, 0, 0, 1, 5, 6, 7, 0);
        default: set_fields(3, 5'h18, 0, 0, 0, 0, 1, 2, 32'hFFFF_FFFC);
      endcase
      tick();
      checks++; if (out_inst !== want[i] || out_illegal !== 1'b0)
        begin failures++; $display("FAIL vector%0d got %h/%b want %h/0", i, out_inst, out_illegal, want[i]); end
      checks++; if (out_addr !== 32'(i * 4))
        begin failures++; $display("FAIL vector%0d_addr got %h want %h", i, out_addr, i * 4); end
    end
    in_valid = 0; tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] held;
    clr = 1; in_valid = 0; tick(); clr = 0;
    in_valid = 1; out_ready = 1; set_fields(1, 5'h04, 0, 0, 0, 3, 4, 0, 32'h123);
    tick();
    held = out_inst;
    checks++; if (held !== 32'h12320193) begin failures++; $display("FAIL bp_first got %h want 12320193", held); end
    out_ready = 0; set_fields(4, 5'h0D, 0, 0, 0, 9, 0, 0, 32'hABCDE000);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      tick();
      checks++; if (out_inst !== 32'h12320193 || out_addr !== 32'h0 || out_valid !== 1'b1)
        begin failures++; $display("FAIL bp_stable got %h@%h v%b want 12320193@0 v1", out_inst, out_addr, out_valid); end
    end
    out_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got %b want 1", in_ready); end
    tick();
    checks++; if (out_inst !== 32'hABCDE4B7 || out_addr !== 32'h4 || out_valid !== 1'b1)
      begin failures++; $display("FAIL bp_second got %h@%h v%b want abcde4b7@4 v1", out_inst, out_addr, out_valid); end
    set_fields(2, 5'h08, 2, 0, 0, 0, 1, 2, 32'h7FF);
    tick();
    checks++; if (out_inst !== 32'h7E20AFA3 || out_addr !== 32'h8 || out_valid !== 1'b1)
      begin failures++; $display("FAIL bp_third got %h@%h v%b want 7e20afa3@8 v1", out_inst, out_addr, out_valid); end
    in_valid = 0; tick();
  endtask

  task automatic test_illegal();
    int unsigned c0;
    c0 = inst_count;
    in_valid = 1; out_ready = 1;
    set_fields(7, 5'h0C, 0, 0, 0, 1, 2, 3, 0);
    tick();
    checks++; if (out_inst !== 32'h13 || out_illegal !== 1'b1)
      begin failures++; $display("FAIL illegal_fmt got %h/%b want 00000013/1", out_inst, out_illegal); end
    set_fields(5, 5'h1B, 0, 0, 0, 1, 0, 0, 32'h1);
    tick();
    checks++; if (out_inst !== 32'h13 || out_illegal !== 1'b1)
      begin failures++; $display("FAIL illegal_j got %h/%b want 00000013/1", out_inst, out_illegal); end
    in_valid = 0; tick();
    checks++; if (inst_count !== 16'(c0 + 2) || out_valid !== 1'b0)
      begin failures++; $display("FAIL illegal_count got %0d v%b want %0d v0", inst_count, out_valid, c0 + 2); end
  endtask

  task automatic test_wrap();
    logic [3:0] want [5];
    want[0] = 4'h0; want[1] = 4'h4; want[2] = 4'h8; want[3] = 4'hC; want[4] = 4'h0;
    clr = 1; in_valid = 0; tick(); clr = 0;
    in_valid = 1; out_ready = 1; set_fields(1, 5'h04, 0, 0, 0, 1, 1, 0, 32'h5);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_addr2 !== want[i] || out_valid2 !== 1'b1)
        begin failures++; $display("FAIL wrap%0d got %h v%b want %h v1", i, out_addr2, out_valid2, want[i]); end
    end
    in_valid = 0; tick();
  endtask

  task automatic test_saturate();
    logic [15:0] want [4];
    want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'hFFFF; want[3] = 16'hFFFF;
    in_valid = 1; out_ready = 1; set_fields(1, 5'h04, 0, 0, 0, 2, 2, 0, 32'h1);
    tick();
    force dut.inst_count = 16'hFFFD;
    #1 release dut.inst_count;
    m_count = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (inst_count !== want[i])
        begin failures++; $display("FAIL sat%0d got %h want %h", i, inst_count, want[i]); end
    end
    in_valid = 0; tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1; out_ready = 0; set_fields(0, 5'h0C, 0, 0, 0, 1, 1, 1, 0);
    tick();
    rst_n = 0; tick(); rst_n = 1; in_valid = 0;
    checks++; if (out_valid !== 1'b0 || out_addr !== 32'h0 || inst_count !== 16'h0 || out_addr2 !== 4'h0)
      begin failures++; $display("FAIL reset_mid got v%b %h %h want v0 0 0", out_valid, out_addr, inst_count); end
  endtask

  task automatic test_clr_drain();
    in_valid = 1; out_ready = 1; set_fields(1, 5'h04, 0, 0, 0, 1, 1, 0, 32'h9);
    tick(); tick();
    checks++; if (out_addr !== 32'h4 || inst_count !== 16'h1)
      begin failures++; $display("FAIL clr_pre got %h/%h want 4/1", out_addr, inst_count); end
    in_valid = 0; clr = 1; tick(); clr = 0;
    checks++; if (out_addr !== 32'h0 || inst_count !== 16'h0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL clr_drain got %h/%h v%b want 0/0 v0", out_addr, inst_count, out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] imm;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 39) == 0);
      imm = $urandom;
      if ($urandom_range(0, 1) == 0) imm[0] = 1'b0;
      set_fields($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), imm);
      #1;
      checks++; if (in_ready !== (!m_valid || out_ready) || out_valid !== m_valid)
        begin failures++; $display("FAIL rand%0d_hs got r%b v%b want v%b", i, in_ready, out_valid, m_valid); end
      checks++; if (out_addr !== m_addr || out_addr2 !== m2_addr || inst_count !== 16'(m_count))
        begin failures++; $display("FAIL rand%0d_ctr got %h/%h/%h want %h/%h/%h", i, out_addr, out_addr2, inst_count, m_addr, m2_addr, m_count); end
      if (m_valid) begin
        checks++; if (out_inst !== m_inst || out_illegal !== m_ill)
          begin failures++; $display("FAIL rand%0d_word got %h/%b want %h/%b", i, out_inst, out_illegal, m_inst, m_ill); end
      end
      tick();
    end
    clr = 0; in_valid = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_vectors();
    test_back_pressure();
    test_illegal();
    test_wrap();
    test_saturate();
    test_reset_mid();
    test_clr_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
